// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - four-channel key synchroniser and debouncer with press and long-press pulses
// Keys are active-low; each channel runs its own debounce FSM.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [3:0] key_raw,
  output logic [3:0] key_db,
  output logic [3:0] press_pulse,
  output logic [3:0] long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_e;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Released (1) is the safe value for the synchroniser after reset.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic          long_q, long_d;
    logic          sync;

    assign sync = sync2_q[g];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        state_q <= REL;
        deb_q   <= '0;
        hold_q  <= '0;
        fired_q <= 1'b0;
        db_q    <= 1'b1;
        press_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        hold_q  <= hold_d;
        fired_q <= fired_d;
        db_q    <= db_d;
        press_q <= press_d;
        long_q  <= long_d;
      end
    end

    always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      hold_d  = hold_q;
      fired_d = fired_q;
      db_d    = db_q;
      press_d = 1'b0;
      long_d  = 1'b0;
      // Hold time keeps running through release bounces; fired_q limits it to one pulse per press.
      if (state_q == PRS || state_q == CHK_R) begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end
      case (state_q)
        REL: begin
          if (!sync) begin
            state_d = CHK_P;
            deb_d   = '0;
          end
        end
        CHK_P: begin
          if (sync) begin
            state_d = REL;
          end else if (deb_q == DEB_LAST) begin
            state_d = PRS;
            db_d    = 1'b0;
            press_d = 1'b1;
            hold_d  = '0;
            fired_d = 1'b0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        PRS: begin
          if (sync) begin
            state_d = CHK_R;
            deb_d   = '0;
          end
        end
        CHK_R: begin
          if (!sync) begin
            state_d = PRS;
          end else if (deb_q == DEB_LAST) begin
            state_d = REL;
            db_d    = 1'b1;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: state_d = REL;
      endcase
    end

    assign key_db[g]      = db_q;
    assign press_pulse[g] = press_q;
    assign long_pulse[g]  = long_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce
// Runs with DEBOUNCE_CYCLES=8 and LONG_CYCLES=32, so press/release latency is 11 edges.
module tb_key_debounce;

  localparam int NEVER = 100000;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] key_raw;
  logic [3:0] key_db;
  logic [3:0] press_pulse;
  logic [3:0] long_pulse;

  int errors = 0;
  int checks = 0;

  key_debounce #(.DEBOUNCE_CYCLES(8), .LONG_CYCLES(32)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .key_raw     (key_raw),
    .key_db      (key_db),
    .press_pulse (press_pulse),
    .long_pulse  (long_pulse)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Steps n cycles (numbered k0+1..k0+n from the stimulus edge) and checks all outputs each cycle.
  task automatic watch(input string tag, input int k0, input int n,
                       input int db_at, input logic [3:0] db_pre, input logic [3:0] db_post,
                       input int p_at, input logic [3:0] p_mask,
                       input int l_at, input logic [3:0] l_mask);
    for (int k = k0 + 1; k <= k0 + n; k++) begin
      tick();
      check($sformatf("%s_db@%0d", tag, k), key_db, (k >= db_at) ? db_post : db_pre);
      check($sformatf("%s_press@%0d", tag, k), press_pulse, (k == p_at) ? p_mask : 4'h0);
      check($sformatf("%s_long@%0d", tag, k), long_pulse, (k == l_at) ? l_mask : 4'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_db"}, key_db, 4'hF);
    check({tag, "_press"}, press_pulse, 4'h0);
    check({tag, "_long"}, long_pulse, 4'h0);
  endtask

  initial begin
    reset_reset = 1'b1;
    key_raw     = 4'hF;
    #1;
    check_reset_outputs("rst0");
    tick();
    tick();
    reset_reset = 1'b0;
    watch("idle", 0, 3, NEVER, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0);

    // Clean press and release on key 0.
    key_raw = 4'hE;
    watch("p0", 0, 20, 11, 4'hF, 4'hE, 11, 4'h1, 0, 4'h0);
    key_raw = 4'hF;
    watch("r0", 0, 12, 11, 4'hE, 4'hF, 0, 4'h0, 0, 4'h0);

    // Bouncing press on key 1: 0,1,0,1 for 3 cycles each, then held low.
    for (int s = 0; s < 4; s++) begin
      key_raw = (s % 2 == 0) ? 4'hD : 4'hF;
      watch("b1", s * 3, 3, NEVER, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0);
    end
    key_raw = 4'hD;
    watch("p1", 0, 14, 11, 4'hF, 4'hD, 11, 4'h2, 0, 4'h0);
    key_raw = 4'hF;
    watch("r1", 0, 12, 11, 4'hD, 4'hF, 0, 4'h0, 0, 4'h0);

    // Long press on key 2 with a 2-cycle release glitch after the long pulse.
    key_raw = 4'hB;
    watch("l2a", 0, 50, 11, 4'hF, 4'hB, 11, 4'h4, 43, 4'h4);
    key_raw = 4'hF;
    watch("l2g", 50, 2, 0, 4'hB, 4'hB, 0, 4'h0, 0, 4'h0);
    key_raw = 4'hB;
    watch("l2b", 52, 8, 0, 4'hB, 4'hB, 0, 4'h0, 0, 4'h0);
    key_raw = 4'hF;
    watch("r2", 0, 12, 11, 4'hB, 4'hF, 0, 4'h0, 0, 4'h0);

    // All four keys at once.
    key_raw = 4'h0;
    watch("pall", 0, 12, 11, 4'hF, 4'h0, 11, 4'hF, 0, 4'h0);
    key_raw = 4'hF;
    watch("rall", 0, 12, 11, 4'h0, 4'hF, 0, 4'h0, 0, 4'h0);

    // Reset while key 3 is in CHK_P, then again while in PRS.
    key_raw = 4'h7;
    watch("c3", 0, 5, NEVER, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0);
    reset_reset = 1'b1;
    #1;
    check_reset_outputs("rst_chk");
    tick();
    check_reset_outputs("rst_chk_hold");
    tick();
    reset_reset = 1'b0;
    watch("p3a", 0, 15, 11, 4'hF, 4'h7, 11, 4'h8, 0, 4'h0);
    reset_reset = 1'b1;
    #1;
    check_reset_outputs("rst_prs");
    tick();
    tick();
    reset_reset = 1'b0;
    watch("p3b", 0, 12, 11, 4'hF, 4'h7, 11, 4'h8, 0, 4'h0);
    key_raw = 4'hF;
    watch("r3", 0, 12, 11, 4'h7, 4'hF, 0, 4'h0, 0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
